// File: rtl/user_saxil_rd_device.sv
// user_saxil_rd_device: AXI4-Lite read-only slave returning address-derived data after a fixed latency
module user_saxil_rd_device #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          NUM_REGS     = 16,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] DATA_PATTERN = 32'hA5A5_0000
) (
  input  logic                  user_saxil_clk,
  input  logic                  user_saxil_rst_n,
  input  logic [ADDR_WIDTH-1:0] user_port_araddr,
  input  logic                  user_port_arvalid,
  output logic                  user_port_arready,
  output logic                  user_port_rvalid,
  input  logic                  user_port_rready,
  output logic [DATA_WIDTH-1:0] user_port_rdata,
  output logic [1:0]            user_port_rresp,
  output logic [15:0]           user_rd_count
);
  localparam int B  = DATA_WIDTH / 8;
  localparam int LB = $clog2(B);
  localparam int CW = READ_LATENCY > 2 ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * B);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0] addr_q, dec_addr, off;
  logic [15:0] rd_count_q;
  logic ar_hs, r_hs, ok;

  assign ar_hs = user_port_arvalid && user_port_arready;
  assign r_hs  = user_port_rvalid && user_port_rready;
  assign user_rd_count = rd_count_q;

  // With a latency of one the response is loaded on the accept edge, before addr_q holds the address
  assign dec_addr = state == IDLE ? user_port_araddr : addr_q;
  assign off      = dec_addr - BASE;
  assign ok       = dec_addr >= BASE && off < SPAN && dec_addr[LB-1:0] == '0;

  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    case (state)
      IDLE: state_nx = ar_hs ? (READ_LATENCY > 1 ? WAIT : RESP) : IDLE;
      WAIT: begin
        state_nx = cnt == LAST ? RESP : WAIT;
        cnt_nx = cnt == LAST ? '0 : cnt + 1'b1;
      end
      RESP: state_nx = r_hs ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge user_saxil_clk or negedge user_saxil_rst_n)
    if (!user_saxil_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      user_port_arready <= 1'b0;
      user_port_rvalid <= 1'b0;
      user_port_rdata <= '0;
      user_port_rresp <= 2'b00;
      rd_count_q <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (ar_hs) addr_q <= user_port_araddr;
      user_port_arready <= state_nx == IDLE;
      user_port_rvalid <= state_nx == RESP;
      if (state_nx == RESP && state != RESP) begin
        user_port_rdata <= ok ? DATA_WIDTH'(DATA_PATTERN) ^ DATA_WIDTH'(off >> LB) : '0;
        user_port_rresp <= ok ? 2'b00 : 2'b10;
      end
      if (r_hs && user_port_rresp == 2'b00 && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
    end
endmodule

// File: tb/tb_user_saxil_rd_device.sv
// tb_user_saxil_rd_device: table, hand-written and random reads against three configurations of the device
module tb_user_saxil_rd_device;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] araddr [3];
  logic arvalid [3], arready [3], rvalid [3], rready [3];
  logic [1:0] rresp [3];
  logic [15:0] cnt [3];
  logic [63:0] rdata [3];
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  logic [15:0] exp_cnt [3];
  int lat [3] = '{2, 1, 2};
  int dw [3] = '{32, 32, 64};
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
    int          hold;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  assign rdata[0] = {32'h0, rd0};
  assign rdata[1] = {32'h0, rd1};
  assign rdata[2] = rd2;

  user_saxil_rd_device dut0 (
    .user_saxil_clk(clk), .user_saxil_rst_n(rst_n), .user_port_araddr(araddr[0]),
    .user_port_arvalid(arvalid[0]), .user_port_arready(arready[0]), .user_port_rvalid(rvalid[0]),
    .user_port_rready(rready[0]), .user_port_rdata(rd0), .user_port_rresp(rresp[0]), .user_rd_count(cnt[0]));
  user_saxil_rd_device #(.READ_LATENCY(1)) dut1 (
    .user_saxil_clk(clk), .user_saxil_rst_n(rst_n), .user_port_araddr(araddr[1]),
    .user_port_arvalid(arvalid[1]), .user_port_arready(arready[1]), .user_port_rvalid(rvalid[1]),
    .user_port_rready(rready[1]), .user_port_rdata(rd1), .user_port_rresp(rresp[1]), .user_rd_count(cnt[1]));
  user_saxil_rd_device #(.DATA_WIDTH(64)) dut2 (
    .user_saxil_clk(clk), .user_saxil_rst_n(rst_n), .user_port_araddr(araddr[2]),
    .user_port_arvalid(arvalid[2]), .user_port_arready(arready[2]), .user_port_rvalid(rvalid[2]),
    .user_port_rready(rready[2]), .user_port_rdata(rd2), .user_port_rresp(rresp[2]), .user_rd_count(cnt[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Register map semantics: word index = (addr - 0x1000) / bytes_per_word over 16 words
  function automatic void model(input int k, input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
    longint unsigned av = 64'(a);
    longint unsigned b = 64'(dw[k] / 8);
    if (av >= 64'h1000 && av < 64'h1000 + 16 * b && av % b == 0) begin
      d = 64'hA5A5_0000 ^ ((av - 64'h1000) / b);
      r = 2'b00;
    end else begin
      d = '0;
      r = 2'b10;
    end
  endfunction

  task automatic rd(input int k, input logic [31:0] a, input int hold, output logic [63:0] d, output logic [1:0] r);
    int n;
    araddr[k] = a;
    arvalid[k] = 1'b1;
    rready[k] = hold == 0;
    n = 0;
    while (!arready[k] && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d ar_accept %h", k, a), 64'(arready[k]), 64'd1);
    @(negedge clk);
    arvalid[k] = 1'b0;
    n = 1;
    while (!rvalid[k] && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d latency %h", k, a), 64'(n), 64'(lat[k]));
    d = rdata[k];
    r = rresp[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("dut%0d stall_ctl %h", k, a), {62'd0, rvalid[k], arready[k]}, 64'b10);
      chk($sformatf("dut%0d stall_rdata %h", k, a), rdata[k], d);
      chk($sformatf("dut%0d stall_rresp %h", k, a), 64'(rresp[k]), 64'(r));
    end
    rready[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("dut%0d r_done %h", k, a), {62'd0, arready[k], rvalid[k]}, 64'b10);
    chk($sformatf("dut%0d rdata_hold %h", k, a), rdata[k], d);
  endtask

  task automatic rd_chk(input int k, input logic [31:0] a, input int hold, input logic [63:0] ed, input logic [1:0] er);
    logic [63:0] d;
    logic [1:0] r;
    rd(k, a, hold, d, r);
    chk($sformatf("dut%0d rdata %h", k, a), d, ed);
    chk($sformatf("dut%0d rresp %h", k, a), 64'(r), 64'(er));
    if (er == 2'b00 && exp_cnt[k] != 16'hFFFF) exp_cnt[k]++;
    chk($sformatf("dut%0d rd_count %h", k, a), 64'(cnt[k]), 64'(exp_cnt[k]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [63:0] ed;
    logic [1:0] er;
    int n;
    tbl[0] = '{32'h0000_1000, 64'hA5A5_0000, 2'b00, 0};
    tbl[1] = '{32'h0000_103C, 64'hA5A5_000F, 2'b00, 0};
    tbl[2] = '{32'h0000_1040, 64'h0,         2'b10, 0};
    tbl[3] = '{32'h0000_0FFC, 64'h0,         2'b10, 0};
    tbl[4] = '{32'h0000_1002, 64'h0,         2'b10, 0};
    tbl[5] = '{32'h0000_1004, 64'hA5A5_0001, 2'b00, 2};
    tbl[6] = '{32'h0000_1020, 64'hA5A5_0008, 2'b00, 1};
    tbl[7] = '{32'h0000_0000, 64'h0,         2'b10, 0};
    tbl[8] = '{32'hFFFF_FFFC, 64'h0,         2'b10, 0};
    tbl[9] = '{32'h0000_1003, 64'h0,         2'b10, 3};
    for (int k = 0; k < 3; k++) begin
      araddr[k] = '0;
      arvalid[k] = 1'b0;
      rready[k] = 1'b1;
      exp_cnt[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ctl", {44'd0, arready[0], rvalid[0], rresp[0], cnt[0]}, 64'd0);
    chk("reset_rdata", rdata[0], 64'd0);
    rst_n = 1'b1;
    #1 chk("arready_at_release", 64'(arready[0]), 64'd0);
    @(negedge clk);
    chk("arready_first_edge", 64'(arready[0]), 64'd1);

    foreach (tbl[i]) rd_chk(0, tbl[i].addr, tbl[i].hold, tbl[i].data, tbl[i].resp);

    // Second AR held during a stalled response must wait for the R handshake
    araddr[0] = 32'h100C;
    arvalid[0] = 1'b1;
    rready[0] = 1'b0;
    @(negedge clk);
    araddr[0] = 32'h1010;
    chk("t4 arready_drop", 64'(arready[0]), 64'd0);
    n = 1;
    while (!rvalid[0] && n < 20) begin @(negedge clk); n++; end
    chk("t4 latency1", 64'(n), 64'd2);
    chk("t4 rdata1", rdata[0], 64'hA5A5_0003);
    repeat (5) begin
      @(negedge clk);
      chk("t4 stall_ctl", {62'd0, rvalid[0], arready[0]}, 64'b10);
      chk("t4 stall_rdata", rdata[0], 64'hA5A5_0003);
      chk("t4 stall_rresp", 64'(rresp[0]), 64'd0);
    end
    rready[0] = 1'b1;
    @(negedge clk);
    chk("t4 r_done", {62'd0, arready[0], rvalid[0]}, 64'b10);
    exp_cnt[0]++;
    @(negedge clk);
    arvalid[0] = 1'b0;
    chk("t4 second_accept", 64'(arready[0]), 64'd0);
    chk("t4 rd_count1", 64'(cnt[0]), 64'(exp_cnt[0]));
    n = 1;
    while (!rvalid[0] && n < 20) begin @(negedge clk); n++; end
    chk("t4 latency2", 64'(n), 64'd2);
    chk("t4 rdata2", rdata[0], 64'hA5A5_0004);
    @(negedge clk);
    exp_cnt[0]++;
    chk("t4 rd_count2", 64'(cnt[0]), 64'(exp_cnt[0]));

    for (int i = 0; i < 150; i++) begin
      a = $urandom_range(0, 9) < 8 ? 32'h0FF0 + $urandom_range(0, 'h60) : $urandom;
      model(0, a, ed, er);
      rd_chk(0, a, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0, ed, er);
    end

    // Reset asserted while the read is waiting out its latency
    araddr[0] = 32'h1000;
    arvalid[0] = 1'b1;
    n = 0;
    while (!arready[0] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("t5 reset_ctl", {44'd0, arready[0], rvalid[0], rresp[0], cnt[0]}, 64'd0);
    chk("t5 reset_rdata", rdata[0], 64'd0);
    for (int k = 0; k < 3; k++) exp_cnt[k] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t5 no_rvalid", 64'(rvalid[0]), 64'd0);
    end
    rd_chk(0, 32'h1004, 0, 64'hA5A5_0001, 2'b00);

    force dut0.rd_count_q = 16'hFFFD;
    #1 release dut0.rd_count_q;
    exp_cnt[0] = 16'hFFFD;
    rd_chk(0, 32'h1000, 0, 64'hA5A5_0000, 2'b00);
    rd_chk(0, 32'h1008, 0, 64'hA5A5_0002, 2'b00);
    rd_chk(0, 32'h1010, 0, 64'hA5A5_0004, 2'b00);
    rd_chk(0, 32'h1041, 0, 64'h0, 2'b10);
    rd_chk(0, 32'h103C, 1, 64'hA5A5_000F, 2'b00);

    rd_chk(1, 32'h1000, 0, 64'hA5A5_0000, 2'b00);
    rd_chk(1, 32'h103C, 2, 64'hA5A5_000F, 2'b00);
    rd_chk(1, 32'h1040, 0, 64'h0, 2'b10);
    rd_chk(2, 32'h1000, 0, 64'hA5A5_0000, 2'b00);
    rd_chk(2, 32'h1008, 0, 64'hA5A5_0001, 2'b00);
    rd_chk(2, 32'h1004, 0, 64'h0, 2'b10);
    rd_chk(2, 32'h1078, 0, 64'hA5A5_000F, 2'b00);
    rd_chk(2, 32'h1080, 0, 64'h0, 2'b10);
    for (int k = 1; k < 3; k++)
      for (int i = 0; i < 40; i++) begin
        a = 32'h0FF0 + $urandom_range(0, 'hA0);
        model(k, a, ed, er);
        rd_chk(k, a, int'($urandom_range(0, 2)), ed, er);
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
